// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a fixed-latency memory,
// tracks them in a valid/address pipe and buffers responses in a small FIFO.
module fetch_queue #(
   parameter int               XLEN        = 32,
   parameter int               DEPTH       = 4,
   parameter int               MEM_LATENCY = 2,
   parameter logic [XLEN-1:0]  RESET_ADDR  = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_addr,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_instr,
   output logic [XLEN-1:0]            out_addr,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              LW      = PW + 1;
   localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

   logic [XLEN-1:0]                   pc;
   logic [MEM_LATENCY-1:0]            vld_pipe;
   logic [MEM_LATENCY-1:0][XLEN-1:0]  addr_pipe;
   logic [DEPTH-1:0][XLEN-1:0]        buf_instr;
   logic [DEPTH-1:0][XLEN-1:0]        buf_addr;
   logic [PW-1:0]                     rd_ptr;
   logic [PW-1:0]                     wr_ptr;
   logic [LW-1:0]                     inflight;
   logic [LW:0]                       occupancy;
   logic                              push;
   logic                              pop;

   assign push      = vld_pipe[MEM_LATENCY-1];
   assign out_valid = (level != '0);
   assign pop       = out_valid & ~stall;
   assign out_instr = buf_instr[rd_ptr];
   assign out_addr  = buf_addr[rd_ptr];
   assign imem_addr = pc;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++)
         inflight = inflight + LW'(vld_pipe[i]);
   end

   // Reserve a buffer slot for every outstanding request so a response can never find the buffer full.
   assign occupancy = {1'b0, level} + {1'b0, inflight} - (LW+1)'(pop);
   assign imem_req  = reset & ~redirect & (occupancy < {1'b0, DEPTH_L});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc        <= RESET_ADDR;
         vld_pipe  <= '0;
         addr_pipe <= '0;
         buf_instr <= '0;
         buf_addr  <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
      end else if (redirect) begin
         pc       <= redirect_addr;
         vld_pipe <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
      end else begin
         if (imem_req)
            pc <= pc + XLEN'(4);
         vld_pipe[0]  <= imem_req;
         addr_pipe[0] <= pc;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
         if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_addr[wr_ptr]  <= addr_pipe[MEM_LATENCY-1];
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
      end
   end

   no_overflow: assert property (@(posedge clock) disable iff (!reset)
      !(push && !redirect && !pop && level == DEPTH_L));

endmodule
